// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multicycle MIPS-subset controller.
// Holds the opcode/funct encodings, the FSM state encoding, the decoded
// instruction classes and the datapath select encodings.
package mc_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_R_ADD, C_R_SUB, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } iclass_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_LUI = 2'b11;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WSRC_ALU = 2'b00;
  localparam logic [1:0] WSRC_MDR = 2'b01;
  localparam logic [1:0] WSRC_NPC = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
// Ports:
//   i_op    - IR[31:26]
//   i_funct - IR[5:0]
//   o_cls   - decoded instruction class (C_ILL for anything unsupported)
// Configuration: MC_CTRL_JAL_EN enables decoding of jal; otherwise op 0x03 is illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output iclass_e    o_cls
);

  always_comb begin
    o_cls = C_ILL;
    case (i_op)
      OP_RTYPE: begin
        if (i_funct == FN_ADDU)      o_cls = C_R_ADD;
        else if (i_funct == FN_SUBU) o_cls = C_R_SUB;
        else                         o_cls = C_ILL;
      end
      OP_ORI: o_cls = C_ORI;
      OP_LUI: o_cls = C_LUI;
      OP_LW:  o_cls = C_LW;
      OP_SW:  o_cls = C_SW;
      OP_BEQ: o_cls = C_BEQ;
      OP_J:   o_cls = C_J;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: o_cls = C_JAL;
`else
      OP_JAL: o_cls = C_ILL;
`endif
      default: o_cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM for the MIPS-subset datapath.
// Sequences IF/ID/EX/MEM/WB around one shared ALU and drives every datapath
// strobe and select combinationally from the current state and IR fields.
// Ports:
//   clk, reset (async, active-high)
//   op, funct  - IR fields; zero - ALU zero flag (sampled by beq in EX)
//   ir_we, pc_we, dm_we, rf_we, retire - strobes, forced low while reset is high
//   pc_src, alu_op, alu_srcb, ext_op, rf_dst, rf_wsrc - datapath selects
//   illegal - sticky flag set when an undecodable instruction enters S_HALT
//   state   - current FSM state for debug
// Configuration: MC_CTRL_JAL_EN (in mc_decode) adds jal as a 2-cycle instruction.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_srcb,
  output logic       ext_op,
  output logic       dm_we,
  output logic       rf_we,
  output logic [1:0] rf_dst,
  output logic [1:0] rf_wsrc,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  state_e  r_state;
  state_e  w_state_d;
  logic    r_illegal;
  iclass_e w_cls;

  logic w_ir_we, w_pc_we, w_dm_we, w_rf_we, w_retire;

  mc_decode u_decode (
    .i_op    (op),
    .i_funct (funct),
    .o_cls   (w_cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IF;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == S_ID && w_cls == C_ILL) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_dm_we   = 1'b0;
    w_rf_we   = 1'b0;
    w_retire  = 1'b0;
    pc_src    = PC_SEQ;
    alu_op    = ALU_ADD;
    alu_srcb  = 1'b0;
    ext_op    = 1'b0;
    rf_dst    = DST_RT;
    rf_wsrc   = WSRC_ALU;

    case (r_state)
      S_IF: begin
        w_ir_we   = 1'b1;
        w_pc_we   = 1'b1;
        pc_src    = PC_SEQ;
        w_state_d = S_ID;
      end

      S_ID: begin
        case (w_cls)
          C_J: begin
            w_pc_we   = 1'b1;
            pc_src    = PC_JMP;
            w_retire  = 1'b1;
            w_state_d = S_IF;
          end
          C_JAL: begin
            w_pc_we   = 1'b1;
            pc_src    = PC_JMP;
            w_rf_we   = 1'b1;
            rf_dst    = DST_RA;
            rf_wsrc   = WSRC_NPC;
            w_retire  = 1'b1;
            w_state_d = S_IF;
          end
          C_ILL:   w_state_d = S_HALT;
          default: w_state_d = S_EX;
        endcase
      end

      S_EX: begin
        case (w_cls)
          C_R_ADD: begin
            alu_op    = ALU_ADD;
            w_state_d = S_WB;
          end
          C_R_SUB: begin
            alu_op    = ALU_SUB;
            w_state_d = S_WB;
          end
          C_ORI: begin
            alu_op    = ALU_OR;
            alu_srcb  = 1'b1;
            w_state_d = S_WB;
          end
          C_LUI: begin
            alu_op    = ALU_LUI;
            alu_srcb  = 1'b1;
            w_state_d = S_WB;
          end
          // sw shares the lw address computation (base + sign-extended offset).
          C_LW, C_SW: begin
            alu_op    = ALU_ADD;
            alu_srcb  = 1'b1;
            ext_op    = 1'b1;
            w_state_d = S_MEM;
          end
          C_BEQ: begin
            alu_op    = ALU_SUB;
            pc_src    = PC_BR;
            w_pc_we   = zero;
            w_retire  = 1'b1;
            w_state_d = S_IF;
          end
          default: w_state_d = S_IF;
        endcase
      end

      S_MEM: begin
        if (w_cls == C_SW) begin
          w_dm_we   = 1'b1;
          w_retire  = 1'b1;
          w_state_d = S_IF;
        end else begin
          w_state_d = S_WB;
        end
      end

      S_WB: begin
        w_rf_we   = 1'b1;
        w_retire  = 1'b1;
        w_state_d = S_IF;
        case (w_cls)
          C_R_ADD, C_R_SUB: rf_dst  = DST_RD;
          C_LW:             rf_wsrc = WSRC_MDR;
          default:          rf_dst  = DST_RT;
        endcase
      end

      S_HALT:  w_state_d = S_HALT;
      default: w_state_d = S_IF;
    endcase
  end

  // Gate write strobes with the raw reset so a reset mid-instruction writes nothing.
  assign ir_we   = w_ir_we  & ~reset;
  assign pc_we   = w_pc_we  & ~reset;
  assign dm_we   = w_dm_we  & ~reset;
  assign rf_we   = w_rf_we  & ~reset;
  assign retire  = w_retire & ~reset;
  assign illegal = r_illegal;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

`ifdef MC_CTRL_JAL_EN
  localparam bit JalEn = 1'b1;
`else
  localparam bit JalEn = 1'b0;
`endif

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_srcb;
    logic       ext_op;
    logic       dm_we;
    logic       rf_we;
    logic [1:0] rf_dst;
    logic [1:0] rf_wsrc;
    logic       retire;
    logic       illegal;
    logic [2:0] state;
  } out_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       ir_we, pc_we, alu_srcb, ext_op, dm_we, rf_we, retire, illegal;
  logic [1:0] pc_src, alu_op, rf_dst, rf_wsrc;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_src   (pc_src),
    .alu_op   (alu_op),
    .alu_srcb (alu_srcb),
    .ext_op   (ext_op),
    .dm_we    (dm_we),
    .rf_we    (rf_we),
    .rf_dst   (rf_dst),
    .rf_wsrc  (rf_wsrc),
    .retire   (retire),
    .illegal  (illegal),
    .state    (state)
  );

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic out_t sample();
    return {ir_we, pc_we, pc_src, alu_op, alu_srcb, ext_op, dm_we, rf_we,
            rf_dst, rf_wsrc, retire, illegal, state};
  endfunction

  function automatic int cpi(input int cls);
    case (cls)
      K_J, K_JAL, K_ILL: return 2;
      K_BEQ:             return 3;
      K_LW:              return 5;
      default:           return 4;
    endcase
  endfunction

  // Reference: expected outputs for cycle 'step' of an instruction of class 'cls'.
  function automatic out_t model(input int cls, input int step, input logic z);
    out_t e = '0;
    bit last = (step == cpi(cls) - 1);
    bit writes = (cls == K_ADDU || cls == K_SUBU || cls == K_ORI || cls == K_LUI ||
                  cls == K_LW);
    if (step < 3)      e.state = 3'(step);
    else if (step == 3) e.state = (cls == K_LW || cls == K_SW) ? 3'd3 : 3'd4;
    else               e.state = 3'd4;
    if (step == 0) begin
      e.ir_we = 1'b1;
      e.pc_we = 1'b1;
    end
    if (step == 1 && (cls == K_J || cls == K_JAL)) begin
      e.pc_we  = 1'b1;
      e.pc_src = 2'b10;
      if (cls == K_JAL) begin
        e.rf_we   = 1'b1;
        e.rf_dst  = 2'b10;
        e.rf_wsrc = 2'b10;
      end
    end
    if (step == 2) begin
      case (cls)
        K_SUBU: e.alu_op = 2'b01;
        K_ORI:  begin e.alu_op = 2'b10; e.alu_srcb = 1'b1; end
        K_LUI:  begin e.alu_op = 2'b11; e.alu_srcb = 1'b1; end
        K_LW:   begin e.alu_srcb = 1'b1; e.ext_op = 1'b1; end
        K_BEQ:  begin e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_we = z; end
        default: ;
      endcase
    end
    if (last && writes) begin
      e.rf_we   = 1'b1;
      e.rf_dst  = (cls == K_ADDU || cls == K_SUBU) ? 2'b01 : 2'b00;
      e.rf_wsrc = (cls == K_LW) ? 2'b01 : 2'b00;
    end
    if (last && cls == K_SW) e.dm_we = 1'b1;
    e.retire = last && (cls != K_ILL);
    return e;
  endfunction

  function automatic logic [5:0] op_of(input int cls);
    case (cls)
      K_ORI: return 6'h0D;
      K_LUI: return 6'h0F;
      K_LW:  return 6'h23;
      K_SW:  return 6'h2B;
      K_BEQ: return 6'h04;
      K_J:   return 6'h02;
      K_JAL: return 6'h03;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] funct_of(input int cls);
    if (cls == K_ADDU) return 6'h21;
    if (cls == K_SUBU) return 6'h23;
    return 6'($urandom_range(0, 63));
  endfunction

  // Runs one instruction from its IF cycle. zsel<0 randomises zero each cycle.
  // abort_at>=0 pulses reset after checking that step.
  task automatic run_instr(input int cls, input logic [5:0] o, input logic [5:0] f,
                           input int zsel, input int abort_at);
    out_t e, m, obs;
    op = o;
    funct = f;
    for (int s = 0; s < cpi(cls); s++) begin
      @(negedge clk);
      zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      #1;
      e = model(cls, s, zero);
      m = '1;
      // sw address-phase selects are not constrained by the path description.
      if (cls == K_SW && s == 2) begin
        m.alu_op   = 2'b00;
        m.alu_srcb = 1'b0;
        m.ext_op   = 1'b0;
      end
      obs = sample();
      check($sformatf("op%02h_fn%02h_step%0d", o, f, s), obs & m, e & m);
      if (s == abort_at) begin
        reset = 1'b1;
        #1;
        check("reset_mid_instr", sample(), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
    end
    if (cls == K_ILL) begin
      for (int h = 0; h < 10; h++) begin
        @(negedge clk);
        zero = 1'($urandom_range(0, 1));
        #1;
        e = '0;
        e.state = 3'd5;
        e.illegal = 1'b1;
        check($sformatf("halt_%0d", h), sample(), e);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("halt_reset", sample(), '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit op_legal(input logic [5:0] o);
    return o == 6'h00 || o == 6'h02 || o == 6'h04 || o == 6'h0D || o == 6'h0F ||
           o == 6'h23 || o == 6'h2B || (JalEn && o == 6'h03);
  endfunction

  initial begin
    logic [5:0] o;
    int cls;
    reset = 1'b1;
    op    = 6'h00;
    funct = 6'h21;
    zero  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("reset_hold_%0d", i), sample(), '0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // addu $3,$1,$2, then lw/sw, beq taken/not, lui/ori, jal
    run_instr(K_ADDU, 6'h00, 6'h21, -1, -1);
    run_instr(K_LW, 6'h23, 6'h04, -1, -1);
    run_instr(K_SW, 6'h2B, 6'h04, -1, -1);
    run_instr(K_BEQ, 6'h04, 6'h00, 1, -1);
    run_instr(K_BEQ, 6'h04, 6'h00, 0, -1);
    run_instr(K_LUI, 6'h0F, 6'h12, -1, -1);
    run_instr(K_ORI, 6'h0D, 6'h34, -1, -1);
    run_instr(K_SUBU, 6'h00, 6'h23, -1, -1);
    run_instr(K_J, 6'h02, 6'h00, -1, -1);
    run_instr(JalEn ? K_JAL : K_ILL, 6'h03, 6'h00, -1, -1);

    // Reset pulse during lw EX, then the next instruction starts cleanly in IF
    run_instr(K_LW, 6'h23, 6'h04, -1, 2);
    run_instr(K_ADDU, 6'h00, 6'h21, -1, -1);

    // Randomised legal instruction stream
    for (int i = 0; i < 60; i++) begin
      cls = $urandom_range(0, JalEn ? 8 : 7);
      run_instr(cls, op_of(cls), funct_of(cls), -1, -1);
    end

    // Illegal encodings: bad R-type funct, random bad opcodes, op 0x3F
    run_instr(K_ILL, 6'h00, 6'h20, -1, -1);
    for (int i = 0; i < 3; i++) begin
      do o = 6'($urandom_range(0, 63)); while (op_legal(o));
      run_instr(K_ILL, o, 6'($urandom_range(0, 63)), -1, -1);
      cls = $urandom_range(0, 7);
      run_instr(cls, op_of(cls), funct_of(cls), -1, -1);
    end
    run_instr(K_ILL, 6'h3F, 6'h00, -1, -1);
    run_instr(K_ADDU, 6'h00, 6'h21, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
